instruction_fetch_unit: RTL and testbench

Front-end fetch stage that sits directly upstream of instruction_decoder. It owns the program counter and issues word-aligned requests to instruction memory. In-order responses are buffered with their PCs in a small FIFO and presented to the decoder over a valid/ready interface. Branch/jump redirects flush all in-flight and buffered fetches and restart fetching at the new target.

---
 rtl/instruction_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word-aligned fetches under a
// credit limit, buffers in-order responses with their PCs, and flushes on
// redirect. Optional misaligned-redirect fault: define IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];

    logic        credit_ok;
    logic        fetch_enable;
    logic        req_fire;
    logic        rsp_fire;
    logic        rsp_push;
    logic        fault_push;
    logic        push;
    logic        pop;
    logic [31:0] push_instr;
    logic [31:0] redirect_target;

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_RUN,
        ST_FAULT_WAIT,
        ST_FAULT_IDLE
    } state_t;

    state_t state;
    logic   misaligned;
    logic   fifo_fault [FIFO_DEPTH];

    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    assign fetch_enable    = (state == ST_RUN);
    // Fault wait only issues no requests, so outstanding == 0 means every discard drained.
    assign fault_push      = (state == ST_FAULT_WAIT) && (outstanding == '0) && !redirect_valid;
    assign out_fault       = fifo_fault[rd_ptr];

    // Fault state: entered on a misaligned redirect, left only by the next redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (redirect_valid) begin
            state <= misaligned ? ST_FAULT_WAIT : ST_RUN;
        end else if (fault_push) begin
            state <= ST_FAULT_IDLE;
        end
    end

    // Fault marker storage alongside the instruction buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_fault[i] <= 1'b0;
            end
        end else if (!redirect_valid && push) begin
            fifo_fault[wr_ptr] <= fault_push;
        end
    end
`else
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign fetch_enable    = 1'b1;
    assign fault_push      = 1'b0;
    assign out_fault       = 1'b0;
`endif

    assign credit_ok        = ({1'b0, outstanding} + {1'b0, count}) < CREDIT_LIMIT;
    assign imem_req_valid   = !rst && !redirect_valid && credit_ok && fetch_enable;
    assign imem_req_addr    = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_fire         = imem_rsp_valid && (outstanding != '0);
    assign rsp_push         = rsp_fire && !redirect_valid && (discard == '0);
    assign push             = rsp_push || fault_push;
    assign push_instr       = fault_push ? 32'h0000_0013 : imem_rsp_data;
    assign out_valid        = (count != '0) && !redirect_valid;
    assign pop              = out_valid && out_ready;
    assign out_instruction  = fifo_instr[rd_ptr];
    assign out_pc           = fifo_pc[rd_ptr];
    assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    // PC tracking, in-flight accounting and discard of flushed responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                discard  <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_fire && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                if (rsp_push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
            end
        end
    end

    // Instruction buffer: simultaneous push and pop both honoured, redirect clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= RESET_PC;
            end
        end else if (redirect_valid) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= push_instr;
                fifo_pc[wr_ptr]    <= rsp_pc;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a queue-based memory and a
// request/response-level reference model produce the expected decoder stream.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [31:0] KEY        = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_fault;

    instruction_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_fault       (out_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int unsigned due;
    } fly_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    fly_t        fly_q[$];
    ent_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          active   = 0;
    int unsigned cyc      = 0;
    logic [31:0] model_pc = RESET_PC;
    bit          fault_mode = 0;
    bit          fault_wait = 0;
    logic [31:0] fault_pc   = '0;

    int unsigned p_ready = 100, p_out = 100, p_rsp = 100, p_redir = 0, p_spur = 0;
    bit          redir_req = 0;
    logic [31:0] redir_target = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(2))
            0:       return r & 32'h0000_0FFC;
            1:       return 32'hFFFF_FFF0 | (r & 32'h0000_000C);
            default: return r & 32'h0000_0FFF;
        endcase
    endfunction

    // Memory + stimulus: one call per cycle, just after the rising edge
    task automatic drive_inputs();
        cyc++;
        imem_req_ready = ($urandom_range(99) < p_ready);
        out_ready      = ($urandom_range(99) < p_out);
        if (redir_req) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            redir_req      = 0;
        end else if ($urandom_range(999) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = rand_target();
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (fly_q.size() > 0) begin
            if (fly_q[0].due <= cyc && $urandom_range(99) < p_rsp) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = fly_q[0].addr ^ KEY;
            end
        end else if ($urandom_range(99) < p_spur) begin
            imem_rsp_valid = 1'b1;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            drive_inputs();
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redir_req    = 1;
        redir_target = tgt;
        run_cycles(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"},  imem_req_addr, RESET_PC);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_instr"}, out_instruction, 32'd0);
        chk({tag, "_out_pc"},    out_pc, RESET_PC);
        chk({tag, "_out_fault"}, 32'(out_fault), 32'd0);
    endtask

    // Reference model: checks request side, then advances on the coming edge
    always @(negedge clk) begin
        if (active) begin
            bit          exp_rv;
            bit          acc;
            bit          rsp_now;
            bit          redir;
            bit          drain;
            logic [31:0] tgt;
            fly_t        h;
            exp_rv = !redirect_valid && !fault_mode &&
                     (fly_q.size() + exp_q.size() < FIFO_DEPTH);
            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
            acc     = imem_req_valid && imem_req_ready;
            rsp_now = imem_rsp_valid;
            redir   = redirect_valid;
            tgt     = redirect_pc;
            #2;
            drain = fault_wait && (fly_q.size() == 0) && !redir;
            if (rsp_now && fly_q.size() > 0) begin
                h = fly_q.pop_front();
                if (h.live && !redir) exp_q.push_back('{h.addr ^ KEY, h.addr, 1'b0});
            end
            if (drain) begin
                exp_q.push_back('{32'h0000_0013, fault_pc, 1'b1});
                fault_wait = 0;
            end
            if (redir) begin
                foreach (fly_q[i]) fly_q[i].live = 0;
                exp_q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
                fault_mode = (tgt[1:0] != 2'b00);
                fault_wait = fault_mode;
                fault_pc   = tgt;
                model_pc   = tgt;
`else
                model_pc   = {tgt[31:2], 2'b00};
`endif
            end else if (acc) begin
                fly_q.push_back('{model_pc, 1'b1, cyc + 1});
                model_pc = model_pc + 32'd4;
            end
        end
    end

    // Monitor: compares every decoder handshake against the scoreboard head
    always @(negedge clk) begin
        if (active) begin
            ent_t e;
            #1;
            chk("out_valid", 32'(out_valid), 32'((exp_q.size() > 0) && !redirect_valid));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_instr", out_instruction, e.instr);
                chk("out_pc",    out_pc,          e.pc);
                chk("out_fault", 32'(out_fault),  32'(e.fault));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst    = 1'b0;
        active = 1;
        drive_inputs();

        // streaming from reset with a 1-cycle memory
        run_cycles(20);
        // decoder stall, then release
        p_out = 0;
        run_cycles(10);
        p_out = 100;
        run_cycles(10);
        // two requests in flight at 0x10/0x14, then flushed
        p_rsp = 0;
        do_redirect(32'h0000_0010);
        run_cycles(4);
        p_rsp = 100;
        do_redirect(32'h0000_0100);
        run_cycles(10);
        // redirect into a busy stream
        do_redirect(32'h0000_0040);
        run_cycles(8);
        do_redirect(32'h0000_0080);
        run_cycles(1);
        do_redirect(32'h0000_00C0);
        run_cycles(8);
        // PC wrap
        do_redirect(32'hFFFF_FFF0);
        run_cycles(12);
        // misaligned target
        do_redirect(32'h0000_0202);
        run_cycles(10);
        do_redirect(32'h0000_0300);
        run_cycles(6);
        // back-to-back redirects with slow memory
        p_rsp = 40;
        do_redirect(32'h0000_0500);
        run_cycles(2);
        do_redirect(32'h0000_0600);
        do_redirect(32'h0000_0700);
        run_cycles(15);

        // randomized traffic
        for (int blk = 0; blk < 25; blk++) begin
            p_ready = $urandom_range(30, 100);
            p_out   = $urandom_range(20, 100);
            p_rsp   = $urandom_range(30, 100);
            p_redir = $urandom_range(0, 60);
            p_spur  = $urandom_range(0, 10);
            run_cycles(100);
        end

        // asynchronous reset in the middle of a cycle
        p_ready = 100; p_out = 100; p_rsp = 100; p_redir = 0; p_spur = 0;
        do_redirect(32'h0000_0800);
        run_cycles(6);
        @(posedge clk);
        #3;
        active         = 0;
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        fly_q.delete();
        exp_q.delete();
        model_pc   = RESET_PC;
        fault_mode = 0;
        fault_wait = 0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        active = 1;
        drive_inputs();
        run_cycles(12);

        @(posedge clk);
        #1;
        active = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
